freq_meas_ctrl: RTL and testbench
=================================

# freq_meas_ctrl

Measurement sequencer that sits around the `freqcheck` pulse counter. It generates the `en_count` gate windows that counter consumes, captures the `count` it reports on `valid`, and averages 2^AVG_LOG2 consecutive windows into one frequency result. The block runs windows back to back while `run` is high, and flags a counter that never reports.

## Interface
- GATE_CYCLES, 1000: gate window length in clk cycles (en_count high time); legal range 1..65535.
- GAP_CYCLES, 100: idle clk cycles between the end of one capture and the next gate; legal range 1..65535.
- AVG_LOG2, 2: windows per result = 2^AVG_LOG2; legal range 0..4.
- TIMEOUT, 64: max clk cycles to wait for `valid` after the gate closes; legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  level enable; measurements repeat while high.
- en_count  out  1  gate to `freqcheck`.
- valid  in  1  one-cycle strobe from `freqcheck`; `count` is valid with it.
- count  in  16  pulses counted in the last gate.
- result  out  16  averaged count; holds until the next result.
- result_valid  out  1  one-cycle strobe with a new `result`.
- timeout_err  out  1  one-cycle strobe when a window times out.
- busy  out  1  high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE: leave for GATE when `run`=1.
  - GATE: en_count=1 for exactly GATE_CYCLES cycles, then go to WAIT.
  - WAIT: on `valid`, accumulate `count` and go to GAP; go to GAP on timeout.
  - GAP: runs GAP_CYCLES cycles. At its end, go to GATE if `run`=1, else IDLE.
- Accumulator: 16+AVG_LOG2 bits, unsigned; it cannot overflow.
- Window index: 0..2^AVG_LOG2-1.
- On the capture that completes the set:
  - result = acc_total >> AVG_LOG2, truncated.
  - result_valid pulses.
  - Accumulator and index clear.
- Timeout: the wait counter reaches TIMEOUT with no `valid`.
  - timeout_err pulses.
  - Accumulator and index clear; the partial set is discarded.
  - Go to GAP.
- `valid` and timeout expiry in the same cycle: `valid` wins and there is no error.
- `valid` seen in IDLE, GATE or GAP is ignored. Nothing is accumulated and there is no error.
- `run` is sampled only in IDLE and at the last GAP cycle.
  - Dropping `run` mid-window lets that window finish, including capture or timeout.
  - Returning to IDLE clears the accumulator and index; a partial set is discarded.
- AVG_LOG2=0: every capture produces a result equal to `count`.

## Timing
- Reset values:
  - en_count=0, result=0, result_valid=0, timeout_err=0, busy=0.
  - State IDLE; accumulator, index and counters all 0.
- All outputs are registered.
- `run` high at edge T in IDLE:
  - busy=1 and en_count=1 from T+1.
  - en_count falls after exactly GATE_CYCLES cycles high.
- WAIT starts on the first cycle with en_count=0. The wait counter counts WAIT cycles 1..TIMEOUT.
- `valid` at edge W in WAIT:
  - Accumulation takes effect at W.
  - On a completing capture, result and result_valid appear at W+1.
  - GAP starts at W+1.
- Timeout: timeout_err is high during the cycle after the TIMEOUT-th WAIT cycle, which is also the first GAP cycle.
- GAP lasts exactly GAP_CYCLES cycles. The next en_count rises on the following cycle, or busy falls if going to IDLE.
- `rst` asserted mid-operation:
  - Next edge gives the reset values.
  - en_count drops immediately; there is no wait for a capture.

## Test plan
- Reset hold: rst=1 for 5 cycles with run=1 and valid toggling -> all outputs 0, en_count never rises.
- Basic averaging (GATE_CYCLES=1000, AVG_LOG2=2): model returns counts 100, 101, 102, 104 one cycle after each gate falls -> result_valid once with result=101; each en_count high time is exactly 1000 cycles.
- Truncation and overflow: AVG_LOG2=2, four counts of 65535 -> result=65535; counts 1, 1, 1, 2 -> result=1.
- Timeout: no `valid` after gate 2 with TIMEOUT=64 -> timeout_err pulses at WAIT cycle 64+1, no result_valid; the next four good windows give the correct average of only those four.
- Boundary race: `valid` in the same cycle the timeout would fire -> captured, timeout_err stays 0. Spurious `valid` during GATE or GAP -> ignored, result unchanged.
- Run control: drop run mid-GATE -> window completes, then IDLE with busy=0. Assert rst during WAIT -> en_count=0, IDLE next cycle, and the partial set does not contribute after restart.

Source files
------------

// File: rtl/freq_meas_ctrl.sv
// Gate/capture sequencer around the freqcheck pulse counter: runs back-to-back
// gate windows, averages 2^AVG_LOG2 captured counts and flags silent counters.
module freq_meas_ctrl #(
    parameter int GATE_CYCLES = 1000,
    parameter int GAP_CYCLES  = 100,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        en_count,
    input  logic        valid,
    input  logic [15:0] count,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        busy
);
    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [15:0]      GATE_LAST = 16'(GATE_CYCLES - 1);
    localparam logic [15:0]      GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GATE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      result_q, result_d;
    logic             en_count_q, en_count_d;
    logic             result_valid_q, result_valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        acc_sum        = acc_q + ACC_W'(count);

        // one counter serves gate length, wait timeout and gap length
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) state_d = S_GATE;
            end
            S_GATE: begin
                if (cnt_q == GATE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT: begin
                // a capture on the last wait cycle still counts, no error
                if (valid) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                    if (idx_q == IDX_LAST) begin
                        result_d       = acc_sum[AVG_LOG2 +: 16];
                        result_valid_d = 1'b1;
                        acc_d          = '0;
                        idx_d          = '0;
                    end else begin
                        acc_d = acc_sum;
                        idx_d = idx_q + 1'b1;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d         = '0;
                    state_d       = S_GAP;
                    timeout_err_d = 1'b1;
                    acc_d         = '0;
                    idx_d         = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (run) begin
                        state_d = S_GATE;
                    end else begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_count_d = (state_d == S_GATE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            result_q       <= '0;
            en_count_q     <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            result_q       <= result_d;
            en_count_q     <= en_count_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign en_count     = en_count_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: randomized windows checked against a set-averaging
// model; a second small instance covers the single-window (AVG_LOG2=0) case.
module tb_freq_meas_ctrl;
    localparam int GATE = 1000;
    localparam int GAP  = 100;
    localparam int AVGL = 2;
    localparam int TMO  = 64;
    localparam int NWIN = 1 << AVGL;
    localparam int KEND = TMO + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] count = '0;
    logic        en_count, result_valid, timeout_err, busy;
    logic [15:0] result;

    logic        run0 = 1'b0;
    logic        valid0 = 1'b0;
    logic [15:0] count0 = '0;
    logic        en0, rv0, to0, busy0;
    logic [15:0] res0;

    freq_meas_ctrl #(.GATE_CYCLES(GATE), .GAP_CYCLES(GAP), .AVG_LOG2(AVGL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .run(run), .en_count(en_count), .valid(valid), .count(count),
        .result(result), .result_valid(result_valid), .timeout_err(timeout_err), .busy(busy));

    freq_meas_ctrl #(.GATE_CYCLES(3), .GAP_CYCLES(2), .AVG_LOG2(0), .TIMEOUT(4)) dut0 (
        .clk(clk), .rst(rst), .run(run0), .en_count(en0), .valid(valid0), .count(count0),
        .result(res0), .result_valid(rv0), .timeout_err(to0), .busy(busy0));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: a set of captured counts, averaged when full
    int          m_sum = 0;
    int          m_n = 0;
    logic [15:0] m_res = '0;
    int          prev_g = 0;   // gap start (WAIT-relative cycle) of the previous window, 0 = from IDLE

    typedef struct {
        int          rise_wait;
        int          hi;
        int          rv_k;
        int          to_k;
        logic [15:0] res_end;
    } obs_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_capture(input logic [15:0] c, output bit done, output logic [15:0] r);
        m_sum += int'(c);
        m_n++;
        done = 1'b0;
        if (m_n == NWIN) begin
            m_res = 16'(m_sum / NWIN);
            done  = 1'b1;
            m_sum = 0;
            m_n   = 0;
        end
        r = m_res;
    endtask

    task automatic model_discard;
        m_sum = 0;
        m_n   = 0;
    endtask

    function automatic int exp_rise();
        return (prev_g > 0) ? prev_g + GAP - KEND : 1;
    endfunction

    // One window: wait for the gate, measure it, answer with valid at WAIT cycle d (0 = never).
    // Sampling point k is the k-th WAIT-relative cycle; observation ends at k = KEND.
    task automatic run_window(input int d, input logic [15:0] c, input bit spur, input int drop_at,
                              output obs_t o);
        o.rise_wait = 0; o.hi = 0; o.rv_k = 0; o.to_k = 0;
        while (en_count !== 1'b1 && o.rise_wait < 4000) begin
            if (spur) begin valid = 1'($urandom_range(0, 1)); count = 16'($urandom); end
            tick;
            o.rise_wait++;
        end
        while (en_count === 1'b1 && o.hi < 4000) begin
            if (drop_at > 0 && o.hi == drop_at) run = 1'b0;
            if (spur) begin valid = 1'($urandom_range(0, 1)); count = 16'($urandom); end
            tick;
            o.hi++;
        end
        for (int k = 1; k < KEND; k++) begin
            if (result_valid === 1'b1 && o.rv_k == 0) o.rv_k = k;
            if (timeout_err === 1'b1 && o.to_k == 0) o.to_k = k;
            valid = (k == d);
            count = (k == d) ? c : 16'($urandom);
            tick;
        end
        valid = 1'b0;
        o.res_end = result;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid = 1'(i % 2); count = 16'($urandom);
            tick;
            checks++;
            if ({en_count, busy, result_valid, timeout_err, result} !== 20'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got en=%b busy=%b rv=%b to=%b res=%0d exp all 0",
                         i, en_count, busy, result_valid, timeout_err, result);
            end
        end
        rst = 1'b0; run = 1'b0; valid = 1'b0;
        m_res = '0; model_discard(); prev_g = 0;
        tick;
        checks++;
        if (busy !== 1'b0 || en_count !== 1'b0) begin
            failures++; $display("FAIL idle_no_run got busy=%b en=%b exp 0 0", busy, en_count);
        end
    endtask

    task automatic test_basic;
        logic [15:0] cs [4];
        obs_t o; bit done; logic [15:0] er;
        cs = '{16'd100, 16'd101, 16'd102, 16'd104};
        run = 1'b1;
        for (int w = 0; w < 4; w++) begin
            run_window(2, cs[w], 1'b0, -1, o);
            model_capture(cs[w], done, er);
            checks++; if (o.hi !== GATE) begin failures++; $display("FAIL basic_gate_len w=%0d got=%0d exp=%0d", w, o.hi, GATE); end
            checks++; if (o.rise_wait !== exp_rise()) begin failures++; $display("FAIL basic_rise w=%0d got=%0d exp=%0d", w, o.rise_wait, exp_rise()); end
            checks++; if (o.rv_k !== (done ? 3 : 0)) begin failures++; $display("FAIL basic_rv_time w=%0d got=%0d exp=%0d", w, o.rv_k, done ? 3 : 0); end
            checks++; if (o.res_end !== er) begin failures++; $display("FAIL basic_result w=%0d got=%0d exp=%0d", w, o.res_end, er); end
            checks++; if (o.to_k !== 0) begin failures++; $display("FAIL basic_no_timeout w=%0d got=%0d exp=0", w, o.to_k); end
            prev_g = 3;
        end
    endtask

    task automatic test_trunc;
        logic [15:0] cs [8];
        obs_t o; bit done; logic [15:0] er;
        cs = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 16'd1, 16'd2};
        for (int w = 0; w < 8; w++) begin
            run_window(1, cs[w], 1'b0, -1, o);
            model_capture(cs[w], done, er);
            checks++; if (o.rise_wait !== exp_rise()) begin failures++; $display("FAIL trunc_rise w=%0d got=%0d exp=%0d", w, o.rise_wait, exp_rise()); end
            checks++; if (o.rv_k !== (done ? 2 : 0)) begin failures++; $display("FAIL trunc_rv_time w=%0d got=%0d exp=%0d", w, o.rv_k, done ? 2 : 0); end
            checks++; if (o.res_end !== er) begin failures++; $display("FAIL trunc_result w=%0d got=%0d exp=%0d", w, o.res_end, er); end
            prev_g = 2;
        end
    endtask

    task automatic test_timeout;
        obs_t o; bit done; logic [15:0] er, c; int d;
        for (int w = 0; w < 6; w++) begin
            d = (w == 1) ? 0 : int'($urandom_range(1, TMO));
            c = 16'($urandom);
            run_window(d, c, 1'b0, -1, o);
            if (d == 0) begin model_discard(); done = 1'b0; er = m_res; end
            else model_capture(c, done, er);
            checks++; if (o.rise_wait !== exp_rise()) begin failures++; $display("FAIL tmo_rise w=%0d got=%0d exp=%0d", w, o.rise_wait, exp_rise()); end
            checks++; if (o.to_k !== (d == 0 ? TMO + 1 : 0)) begin failures++; $display("FAIL tmo_err_time w=%0d got=%0d exp=%0d", w, o.to_k, d == 0 ? TMO + 1 : 0); end
            checks++; if (o.rv_k !== (done ? d + 1 : 0)) begin failures++; $display("FAIL tmo_rv_time w=%0d got=%0d exp=%0d", w, o.rv_k, done ? d + 1 : 0); end
            checks++; if (o.res_end !== er) begin failures++; $display("FAIL tmo_result w=%0d got=%0d exp=%0d", w, o.res_end, er); end
            prev_g = (d == 0) ? TMO + 1 : d + 1;
        end
    endtask

    task automatic test_race;
        obs_t o; bit done; logic [15:0] er, c;
        for (int w = 0; w < 4; w++) begin
            c = 16'($urandom);
            run_window(TMO, c, 1'b1, -1, o);
            model_capture(c, done, er);
            checks++; if (o.to_k !== 0) begin failures++; $display("FAIL race_no_timeout w=%0d got=%0d exp=0", w, o.to_k); end
            checks++; if (o.rv_k !== (done ? TMO + 1 : 0)) begin failures++; $display("FAIL race_rv_time w=%0d got=%0d exp=%0d", w, o.rv_k, done ? TMO + 1 : 0); end
            checks++; if (o.res_end !== er) begin failures++; $display("FAIL race_result w=%0d got=%0d exp=%0d", w, o.res_end, er); end
            prev_g = TMO + 1;
        end
    endtask

    task automatic test_random;
        obs_t o; bit done; logic [15:0] er, c; int d;
        for (int w = 0; w < 10; w++) begin
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
            c = 16'($urandom);
            run_window(d, c, 1'($urandom_range(0, 1)), -1, o);
            if (d == 0) begin model_discard(); done = 1'b0; er = m_res; end
            else model_capture(c, done, er);
            checks++; if (o.hi !== GATE) begin failures++; $display("FAIL rnd_gate_len w=%0d got=%0d exp=%0d", w, o.hi, GATE); end
            checks++; if (o.rise_wait !== exp_rise()) begin failures++; $display("FAIL rnd_rise w=%0d got=%0d exp=%0d", w, o.rise_wait, exp_rise()); end
            checks++; if (o.to_k !== (d == 0 ? TMO + 1 : 0)) begin failures++; $display("FAIL rnd_err_time w=%0d got=%0d exp=%0d", w, o.to_k, d == 0 ? TMO + 1 : 0); end
            checks++; if (o.rv_k !== (done ? d + 1 : 0)) begin failures++; $display("FAIL rnd_rv_time w=%0d got=%0d exp=%0d", w, o.rv_k, done ? d + 1 : 0); end
            checks++; if (o.res_end !== er) begin failures++; $display("FAIL rnd_result w=%0d got=%0d exp=%0d", w, o.res_end, er); end
            prev_g = (d == 0) ? TMO + 1 : d + 1;
        end
    endtask

    task automatic test_run_ctrl;
        obs_t o; bit done; logic [15:0] er, c; int n;
        // drop run mid-gate: the window still completes, then IDLE
        run_window(5, 16'd777, 1'b0, 300, o);
        model_capture(16'd777, done, er);
        checks++; if (o.hi !== GATE) begin failures++; $display("FAIL drop_gate_len got=%0d exp=%0d", o.hi, GATE); end
        checks++; if (o.rv_k !== (done ? 6 : 0)) begin failures++; $display("FAIL drop_rv_time got=%0d exp=%0d", o.rv_k, done ? 6 : 0); end
        checks++; if (o.res_end !== er) begin failures++; $display("FAIL drop_result got=%0d exp=%0d", o.res_end, er); end
        model_discard(); prev_g = 0;
        repeat (6 + GAP - KEND - 1) tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy_last_gap got=%b exp=1", busy); end
        tick;
        checks++; if (busy !== 1'b0 || en_count !== 1'b0) begin failures++; $display("FAIL drop_idle got busy=%b en=%b exp 0 0", busy, en_count); end
        n = 0;
        repeat (20) begin tick; if (en_count !== 1'b0) n++; end
        checks++; if (n !== 0) begin failures++; $display("FAIL drop_stays_idle got=%0d gate cycles exp=0", n); end

        // partial set, then reset in WAIT
        run = 1'b1;
        run_window(4, 16'd60000, 1'b0, -1, o);
        model_capture(16'd60000, done, er);
        prev_g = 5;
        n = 0;
        while (en_count !== 1'b1 && n < 4000) begin tick; n++; end
        checks++; if (n !== exp_rise()) begin failures++; $display("FAIL rst_win_rise got=%0d exp=%0d", n, exp_rise()); end
        n = 0;
        while (en_count === 1'b1 && n < 4000) begin tick; n++; end
        tick; tick;
        rst = 1'b1; tick; rst = 1'b0;
        checks++;
        if ({en_count, busy, result_valid, timeout_err, result} !== 20'd0) begin
            failures++;
            $display("FAIL rst_in_wait got en=%b busy=%b rv=%b to=%b res=%0d exp all 0",
                     en_count, busy, result_valid, timeout_err, result);
        end
        model_discard(); m_res = '0; prev_g = 0;
        for (int w = 0; w < 4; w++) begin
            c = 16'($urandom);
            run_window(2, c, 1'b0, -1, o);
            model_capture(c, done, er);
            checks++; if (o.rise_wait !== exp_rise()) begin failures++; $display("FAIL post_rst_rise w=%0d got=%0d exp=%0d", w, o.rise_wait, exp_rise()); end
            checks++; if (o.rv_k !== (done ? 3 : 0)) begin failures++; $display("FAIL post_rst_rv w=%0d got=%0d exp=%0d", w, o.rv_k, done ? 3 : 0); end
            checks++; if (o.res_end !== er) begin failures++; $display("FAIL post_rst_result w=%0d got=%0d exp=%0d", w, o.res_end, er); end
            prev_g = 3;
        end
    endtask

    task automatic test_avg0;
        logic [15:0] c; int n;
        run = 1'b0; run0 = 1'b1;
        for (int w = 0; w < 6; w++) begin
            c = 16'($urandom);
            n = 0;
            while (en0 !== 1'b1 && n < 100) begin tick; n++; end
            n = 0;
            while (en0 === 1'b1 && n < 100) begin tick; n++; end
            checks++; if (n !== 3) begin failures++; $display("FAIL avg0_gate_len w=%0d got=%0d exp=3", w, n); end
            valid0 = 1'b1; count0 = c;
            tick;
            valid0 = 1'b0;
            checks++;
            if (rv0 !== 1'b1 || res0 !== c) begin
                failures++; $display("FAIL avg0_result w=%0d got rv=%b res=%0d exp rv=1 res=%0d", w, rv0, res0, c);
            end
        end
        run0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trunc();
        test_timeout();
        test_race();
        test_random();
        test_run_ctrl();
        test_avg0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
